// File: rtl/rst_seq.sv
// Reset sequencer: asserts every domain reset request, then releases the domains
// one at a time in index order, waiting for each domain's synchronized ack and a
// programmable gap before moving on. The highest index (CPU) is released last.
module rst_seq #(
  parameter int unsigned NUM_DOM   = 8,
  parameter int unsigned DLY_W     = 8,
  parameter int unsigned TMO_W     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_F100,
  parameter int unsigned DEF_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dmem_addr,
  input  logic [3:0]         dmem_rmask,
  input  logic [3:0]         dmem_wmask,
  input  logic [31:0]        dmem_wdata,
  output logic [31:0]        seq_rdata,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic               seq_busy,
  output logic               seq_err
);

  localparam int unsigned IdxW    = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int unsigned ErrBits = (NUM_DOM < 16) ? NUM_DOM : 16;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_DOM - 1);
  localparam logic [TMO_W-1:0] TmoMax  = '1;

  typedef enum logic [2:0] {StHold, StRel, StWait, StGap, StNext, StDone} state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]   lim_q, lim_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [NUM_DOM-1:0] hold_q, hold_d;
  logic [NUM_DOM-1:0] err_q, err_d;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic [NUM_DOM-1:0] passed;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        bmask, status_rd, hold_wr;
  logic [DLY_W-1:0]   delay_wr;
  logic               rd_en, wr_en, start, err_clr;
  logic               sel_ctrl, sel_status, sel_delay, sel_hold;
  logic               unused_bits;

  assign rd_en      = |dmem_rmask;
  assign wr_en      = |dmem_wmask;
  assign sel_ctrl   = (dmem_addr == BASE_ADDR);
  assign sel_status = (dmem_addr == BASE_ADDR + 32'd4);
  assign sel_delay  = (dmem_addr == BASE_ADDR + 32'd8);
  assign sel_hold   = (dmem_addr == BASE_ADDR + 32'd12);
  assign bmask      = {{8{dmem_wmask[3]}}, {8{dmem_wmask[2]}},
                       {8{dmem_wmask[1]}}, {8{dmem_wmask[0]}}};
  assign start      = wr_en && sel_ctrl && dmem_wmask[0] && dmem_wdata[0];
  assign err_clr    = wr_en && sel_status && dmem_wmask[0] && dmem_wdata[1];
  assign unused_bits = ^{dmem_wdata, bmask};

  // Byte-masked register writes and status word assembly.
  always_comb begin
    delay_wr = (delay_q & ~bmask[DLY_W-1:0]) | (dmem_wdata[DLY_W-1:0] & bmask[DLY_W-1:0]);
    hold_wr  = (32'(hold_q) & ~bmask) | (dmem_wdata & bmask);
    delay_d  = (wr_en && sel_delay) ? delay_wr : delay_q;
    hold_d   = (wr_en && sel_hold) ? hold_wr[NUM_DOM-1:0] : hold_q;
    status_rd    = '0;
    status_rd[0] = seq_busy;
    status_rd[1] = seq_err;
    for (int k = 0; k < ErrBits; k++) begin
      status_rd[16+k] = err_q[k];
    end
  end

  // Read data is registered and reflects pre-write state.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      if (sel_status)     rdata_d = status_rd;
      else if (sel_delay) rdata_d = 32'(delay_q);
      else if (sel_hold)  rdata_d = 32'(hold_q);
    end
  end

  // Domains the sequence has already reached follow HOLD directly.
  always_comb begin
    for (int k = 0; k < NUM_DOM; k++) begin
      passed[k] = (state_q == StDone) || (IdxW'(k) < idx_q) ||
                  ((IdxW'(k) == idx_q) && (state_q inside {StWait, StGap, StNext}));
    end
  end

  // Sequencer next-state: counts, release order, ack timeout and restart.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    dom_rst_d = dom_rst_q;
    if (err_clr) err_d = '0;
    for (int k = 0; k < NUM_DOM; k++) begin
      if (passed[k]) dom_rst_d[k] = hold_d[k];
    end
    unique case (state_q)
      StHold: begin
        if (cnt_q == lim_q) begin
          state_d = StRel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DLY_W'(1);
        end
      end
      StRel: begin
        // HOLD for a pending domain is sampled only here.
        if (hold_q[idx_q]) begin
          state_d = StNext;
        end else begin
          dom_rst_d[idx_q] = 1'b0;
          tmo_d            = '0;
          state_d          = StWait;
        end
      end
      StWait: begin
        if (!dom_ack[idx_q]) begin
          state_d = StGap;
          cnt_d   = '0;
          lim_d   = delay_q;
        end else if (tmo_q == TmoMax) begin
          err_d[idx_q] = 1'b1;
          state_d      = StGap;
          cnt_d        = '0;
          lim_d        = delay_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StGap: begin
        if (cnt_q == lim_q) state_d = StNext;
        else                cnt_d   = cnt_q + DLY_W'(1);
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StRel;
        end
      end
      StDone: begin
        if (start) begin
          state_d   = StHold;
          idx_d     = '0;
          cnt_d     = '0;
          lim_d     = delay_q;
          dom_rst_d = '1;
        end
      end
      default: state_d = StHold;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      lim_q     <= DLY_W'(DEF_DELAY);
      delay_q   <= DLY_W'(DEF_DELAY);
      idx_q     <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      err_q     <= '0;
      dom_rst_q <= '1;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      delay_q   <= delay_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      dom_rst_q <= dom_rst_d;
      rdata_q   <= rdata_d;
    end
  end

  assign dom_rst   = dom_rst_q;
  assign seq_rdata = rdata_q;
  assign seq_busy  = (state_q != StDone);
  assign seq_err   = |err_q;

endmodule
